hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: MUL_LAT, default 3, multiply latency in cycles (2..15); CNT_W, default 32, stall-counter width.
REQ-002 Ports SHALL be, one per line, clock and reset first:
 clk  in  1  single clock; all state on rising edge
 rst_n  in  1  reset, asynchronous, active-low
 id_valid  in  1  ID holds a decoded instruction
 id_reg1_read / id_reg2_read  in  1 each  source operand read enables
 id_reg1_addr / id_reg2_addr  in  5 each  source register numbers
 id_wreg_write  in  1  instruction writes a GPR
 id_wreg_addr  in  5  destination GPR
 id_is_load  in  1  LB/LBU/LH/LHU/LW
 id_is_muldiv  in  1  MULT/MULTU/MUL
 id_uses_hilo  in  1  MFHI/MFLO/MTHI/MTLO
 mem_stall  in  1  memory not ready; freeze pipeline
 flush  in  1  exception flush
 stall  out  1  hold PC, IF/ID
 bubble  out  1  inject OP_NOP into EX
 issue  out  1  ID instruction advances to EX this cycle
 muldiv_start  out  1  one-cycle start pulse to multiplier
 muldiv_done  out  1  one-cycle HI/LO/GPR write pulse
 muldiv_busy  out  1  multiplier FSM not IDLE
 stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Function
REQ-003 A registered EX slot SHALL hold {valid, is_load, addr} of the instruction issued last cycle.
REQ-004 load_use SHALL be id_valid & ex.valid & ex.is_load & ex.addr!=0 & ((id_reg1_read & id_reg1_addr==ex.addr) | (id_reg2_read & id_reg2_addr==ex.addr)).
REQ-005 The multiplier FSM SHALL have states IDLE, BUSY, DONE with a 4-bit down-counter.
REQ-006 IDLE->BUSY on issue & id_is_muldiv: counter loads MUL_LAT-2, muldiv_start=1 that cycle; the FSM latches mul_wgpr=id_wreg_write and mul_dest=id_wreg_addr.
REQ-007 BUSY: counter decrements each non-frozen cycle; at counter==0, BUSY->DONE.
REQ-008 DONE: muldiv_done=1 for exactly one cycle, then ->IDLE; total start-to-done = MUL_LAT cycles absent mem_stall.
REQ-009 muldiv_hazard SHALL be id_valid & state!=IDLE & (id_is_muldiv | id_uses_hilo | (mul_wgpr & mul_dest!=0 & (reads of mul_dest on either port | (id_wreg_write & id_wreg_addr==mul_dest)))).
REQ-010 hazard = load_use | muldiv_hazard; in DONE, dependents SHALL still stall (result forwarded next cycle).
REQ-011 Priority SHALL be flush > mem_stall > hazard.
REQ-012 flush: stall=0, bubble=1, issue=0; EX slot cleared next edge; FSM unaffected; stall_cnt unchanged.
REQ-013 mem_stall (no flush): stall=1, bubble=0, issue=0; EX slot, FSM, counter and stall_cnt frozen; muldiv_start/muldiv_done forced 0 and the DONE pulse deferred until the freeze ends.
REQ-014 hazard only: stall=1, bubble=1, issue=0; EX slot loads empty; stall_cnt increments, saturating at all-ones.
REQ-015 Otherwise issue=id_valid, stall=0, bubble=~id_valid; EX slot loads {id_valid, id_is_load, id_wreg_write?id_wreg_addr:0}.
REQ-016 stall, bubble, issue and muldiv_start SHALL be combinational from current state and inputs; all other state registered.
REQ-017 Register 0 SHALL never create a dependency.

Reset
REQ-018 rst_n low SHALL asynchronously clear EX slot, FSM to IDLE, counter, mul_wgpr, mul_dest and stall_cnt; all outputs 0 except bubble=~id_valid combinationally; reset mid-multiply abandons it with no muldiv_done.

Verification
REQ-019 LW $5 then ADDU $6,$5,$7 back-to-back -> one cycle stall=1,bubble=1,stall_cnt 0->1, then issue=1.
REQ-020 LW $0 then reader of $0 -> no stall; LW $5 then instruction reading only $8 -> no stall.
REQ-021 MULT at cycle 0 (MUL_LAT=3), MFLO next -> muldiv_start@0, stall cycles 1-3, muldiv_done@3, MFLO issues @4.
REQ-022 MUL $4 in flight, ADDU reading $4 -> stalls until cycle after muldiv_done; independent ADDU issues without stall.
REQ-023 mem_stall held 2 cycles mid-BUSY -> muldiv_done delayed by exactly 2 cycles; stall_cnt unchanged during freeze.
REQ-024 flush and load_use same cycle -> bubble=1, stall=0, EX slot empty next cycle; rst_n low mid-BUSY -> muldiv_busy=0 immediately, no muldiv_done.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-order pipeline interlock for the ID->EX boundary.
//   Detects load-use hazards against the instruction in EX and hazards
//   against an in-flight multi-cycle multiply. Resolves flush, memory
//   freeze and hazard stalls, and counts hazard-stall cycles.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   id_*                 decoded instruction in ID
//   mem_stall, flush     memory freeze request, exception flush
//   stall, bubble, issue pipeline control (combinational)
//   muldiv_start/done    one-cycle multiplier start / result-write pulses
//   muldiv_busy          multiplier not idle
//   stall_cnt            saturating hazard-stall cycle count
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_reg1_read,
  input  logic             id_reg2_read,
  input  logic [4:0]       id_reg1_addr,
  input  logic [4:0]       id_reg2_addr,
  input  logic             id_wreg_write,
  input  logic [4:0]       id_wreg_addr,
  input  logic             id_is_load,
  input  logic             id_is_muldiv,
  input  logic             id_uses_hilo,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic             issue,
  output logic             muldiv_start,
  output logic             muldiv_done,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);

  mul_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mul_wgpr;
  logic [4:0] mul_dest;

  logic       ex_valid;
  logic       ex_is_load;
  logic [4:0] ex_addr;

  logic freeze;
  logic load_use;
  logic muldiv_hazard;
  logic hazard;
  logic hazard_stall;
  logic dest_dep;

  // Flush overrides a memory freeze: the multiplier keeps running then.
  assign freeze = mem_stall & ~flush;

  assign load_use = id_valid & ex_valid & ex_is_load & (ex_addr != 5'd0) &
                    ((id_reg1_read & (id_reg1_addr == ex_addr)) |
                     (id_reg2_read & (id_reg2_addr == ex_addr)));

  assign dest_dep = mul_wgpr & (mul_dest != 5'd0) &
                    ((id_reg1_read  & (id_reg1_addr == mul_dest)) |
                     (id_reg2_read  & (id_reg2_addr == mul_dest)) |
                     (id_wreg_write & (id_wreg_addr == mul_dest)));

  // DONE still counts as in flight: the result is only forwardable next cycle.
  assign muldiv_hazard = id_valid & (state != S_IDLE) &
                         (id_is_muldiv | id_uses_hilo | dest_dep);

  assign hazard       = load_use | muldiv_hazard;
  assign hazard_stall = ~flush & ~mem_stall & hazard;

  // Outputs are held quiet while reset is asserted; bubble tracks id_valid.
  always_comb begin
    stall  = 1'b0;
    bubble = ~id_valid;
    issue  = 1'b0;
    if (rst_n) begin
      if (flush) begin
        bubble = 1'b1;
      end else if (mem_stall) begin
        stall  = 1'b1;
        bubble = 1'b0;
      end else if (hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else begin
        issue  = id_valid;
      end
    end
  end

  assign muldiv_start = issue & id_is_muldiv;
  assign muldiv_done  = (state == S_DONE) & ~freeze;
  assign muldiv_busy  = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!freeze) begin
      unique case (state)
        S_IDLE: begin
          if (muldiv_start) begin
            state_nxt = S_BUSY;
            cnt_nxt   = MUL_INIT;
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) state_nxt = S_DONE;
          else             cnt_nxt   = cnt - 4'd1;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mul_wgpr <= 1'b0;
      mul_dest <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (muldiv_start) begin
        mul_wgpr <= id_wreg_write;
        mul_dest <= id_wreg_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_addr    <= '0;
    end else if (flush || (!mem_stall && hazard)) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_addr    <= '0;
    end else if (!mem_stall) begin
      ex_valid   <= id_valid;
      ex_is_load <= id_is_load;
      ex_addr    <= id_wreg_write ? id_wreg_addr : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int ML = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_reg1_read, id_reg2_read;
  logic [4:0]    id_reg1_addr, id_reg2_addr, id_wreg_addr;
  logic          id_wreg_write, id_is_load, id_is_muldiv, id_uses_hilo;
  logic          mem_stall, flush;
  logic          stall, bubble, issue, muldiv_start, muldiv_done, muldiv_busy;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.MUL_LAT(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_wreg_write(id_wreg_write), .id_wreg_addr(id_wreg_addr),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .id_uses_hilo(id_uses_hilo),
    .mem_stall(mem_stall), .flush(flush),
    .stall(stall), .bubble(bubble), .issue(issue),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done), .muldiv_busy(muldiv_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: EX slot contents, multiply age in unfrozen cycles
  // since start (0 = none in flight, ML = result cycle), plain stall count.
  int         m_ex_v, m_ex_ld, m_ex_a;
  int         m_age, m_wgpr, m_dest, m_cnt;

  // Snapshot of DUT outputs at the last checked cycle.
  logic          s_stall, s_bubble, s_issue, s_start, s_done, s_busy;
  logic [CW-1:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ex_v = 0; m_ex_ld = 0; m_ex_a = 0;
    m_age = 0; m_wgpr = 0; m_dest = 0; m_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic r1, input int a1, input logic r2, input int a2,
                       input logic ww, input int wa, input logic ld, input logic md,
                       input logic hl, input logic ms, input logic fl);
    int  lu, mh, hz, e_st, e_bb, e_is, e_start, e_done, frz;
    @(negedge clk);
    id_valid = v; id_reg1_read = r1; id_reg1_addr = 5'(a1);
    id_reg2_read = r2; id_reg2_addr = 5'(a2);
    id_wreg_write = ww; id_wreg_addr = 5'(wa);
    id_is_load = ld; id_is_muldiv = md; id_uses_hilo = hl;
    mem_stall = ms; flush = fl;
    #1;
    frz = ms && !fl;
    lu = v && m_ex_v && m_ex_ld && m_ex_a != 0 &&
         ((r1 && a1 == m_ex_a) || (r2 && a2 == m_ex_a));
    mh = v && m_age > 0 &&
         (md || hl || (m_wgpr && m_dest != 0 &&
          ((r1 && a1 == m_dest) || (r2 && a2 == m_dest) || (ww && wa == m_dest))));
    hz = lu || mh;
    if (fl)      begin e_st = 0; e_bb = 1; e_is = 0; end
    else if (ms) begin e_st = 1; e_bb = 0; e_is = 0; end
    else if (hz) begin e_st = 1; e_bb = 1; e_is = 0; end
    else         begin e_st = 0; e_bb = !v; e_is = v; end
    e_start = e_is && md;
    e_done  = (m_age == ML) && !frz;
    s_stall = stall; s_bubble = bubble; s_issue = issue;
    s_start = muldiv_start; s_done = muldiv_done; s_busy = muldiv_busy; s_cnt = stall_cnt;
    chk("stall", 32'(stall), 32'(e_st));
    chk("bubble", 32'(bubble), 32'(e_bb));
    chk("issue", 32'(issue), 32'(e_is));
    chk("muldiv_start", 32'(muldiv_start), 32'(e_start));
    chk("muldiv_done", 32'(muldiv_done), 32'(e_done));
    chk("muldiv_busy", 32'(muldiv_busy), 32'(m_age > 0));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (fl || (!ms && hz)) begin m_ex_v = 0; m_ex_ld = 0; m_ex_a = 0; end
    else if (!ms) begin m_ex_v = v; m_ex_ld = ld; m_ex_a = ww ? wa : 0; end
    if (m_age > 0 && !frz) m_age = (m_age == ML) ? 0 : m_age + 1;
    if (e_start) begin m_age = 1; m_wgpr = ww; m_dest = wa; end
    if (!fl && !ms && hz && m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  task automatic nop(input logic ms = 0, input logic fl = 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ms, fl);
  endtask
  task automatic alu(input int d, input int s1, input int s2, input logic fl = 0);
    drive(1, 1, s1, 1, s2, 1, d, 0, 0, 0, 0, fl);
  endtask
  task automatic load(input int d, input int base);
    drive(1, 1, base, 0, 0, 1, d, 1, 0, 0, 0, 0);
  endtask
  task automatic mult();
    drive(1, 1, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic mul(input int d, input int s1, input int s2);
    drive(1, 1, s1, 1, s2, 1, d, 0, 1, 0, 0, 0);
  endtask
  task automatic mflo(input int d);
    drive(1, 0, 0, 0, 0, 1, d, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(muldiv_busy), 32'd0);
    chk("rst_done", 32'(muldiv_done), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_bubble", 32'(bubble), 32'(!id_valid));
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [CW-1:0] cnt0;
    rst_n = 1'b1;
    id_valid = 0; id_reg1_read = 0; id_reg2_read = 0; id_reg1_addr = 0; id_reg2_addr = 0;
    id_wreg_write = 0; id_wreg_addr = 0; id_is_load = 0; id_is_muldiv = 0; id_uses_hilo = 0;
    mem_stall = 0; flush = 0;
    model_reset();
    do_reset();

    // Load-use: one stall cycle, counter 0 -> 1, then issue.
    load(5, 1);
    chk("lu_load_issue", 32'(s_issue), 32'd1);
    alu(6, 5, 7);
    chk("lu_stall", 32'(s_stall), 32'd1);
    chk("lu_bubble", 32'(s_bubble), 32'd1);
    chk("lu_cnt0", 32'(s_cnt), 32'd0);
    alu(6, 5, 7);
    chk("lu_reissue", 32'(s_issue), 32'd1);
    chk("lu_cnt1", 32'(s_cnt), 32'd1);

    // Register 0 and unrelated registers never interlock.
    load(0, 1);
    alu(9, 0, 0);
    chk("r0_no_stall", 32'(s_issue), 32'd1);
    load(5, 1);
    alu(9, 8, 8);
    chk("indep_no_stall", 32'(s_issue), 32'd1);

    // MULT then MFLO: start@0, stalls 1-3, done@3, issue@4.
    mult();
    chk("mult_start", 32'(s_start), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      mflo(10);
      chk("mflo_stall", 32'(s_stall), 32'd1);
      chk("mflo_done", 32'(s_done), 32'(c == 3));
    end
    mflo(10);
    chk("mflo_issue", 32'(s_issue), 32'd1);

    // MUL $4: independent issues, dependent waits until after done.
    mul(4, 1, 2);
    alu(11, 13, 14);
    chk("mul_indep", 32'(s_issue), 32'd1);
    alu(12, 4, 3);
    chk("mul_dep_stall2", 32'(s_stall), 32'd1);
    alu(12, 4, 3);
    chk("mul_dep_stall3", 32'(s_stall), 32'd1);
    chk("mul_dep_done3", 32'(s_done), 32'd1);
    alu(12, 4, 3);
    chk("mul_dep_issue", 32'(s_issue), 32'd1);

    // Two frozen cycles mid-BUSY push done from cycle 3 to cycle 5.
    mult();
    nop();
    cnt0 = s_cnt;
    nop(1);
    chk("frz_done1", 32'(s_done), 32'd0);
    nop(1);
    chk("frz_cnt", 32'(s_cnt), 32'(cnt0));
    nop();
    chk("frz_not_yet", 32'(s_done), 32'd0);
    nop();
    chk("frz_done_late", 32'(s_done), 32'd1);

    // Flush wins over load-use and empties EX.
    load(5, 1);
    alu(6, 5, 7, 1);
    chk("fl_bubble", 32'(s_bubble), 32'd1);
    chk("fl_stall", 32'(s_stall), 32'd0);
    alu(6, 5, 7);
    chk("fl_ex_empty", 32'(s_issue), 32'd1);

    // Reset mid-multiply abandons it.
    mult();
    nop();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      nop();
      chk("rst_no_done", 32'(s_done), 32'd0);
    end

    // Randomized traffic against the model, including counter saturation.
    for (int n = 0; n < 600; n++) begin
      logic v, r1, r2, ww, ld, md, hl, ms, fl;
      int a1, a2, wa, kind;
      v  = ($urandom_range(0, 9) < 8);
      kind = $urandom_range(0, 9);
      ld = (kind < 3); md = (kind == 3); hl = (kind == 4);
      r1 = $urandom_range(0, 1); r2 = $urandom_range(0, 1);
      ww = $urandom_range(0, 3) != 0;
      a1 = $urandom_range(0, 4); a2 = $urandom_range(0, 4); wa = $urandom_range(0, 4);
      ms = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 6);
      drive(v, r1, a1, r2, a2, ww, wa, ld, md, hl, ms, fl);
      if (n == 300) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
